// File: rtl/fetch_stage_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fetch_stage_if
// Brief    : Hazard controls, instruction-ROM bus and IF/ID outputs of fetch.
// Revision : 1.0
// ----------------------------------------------------------------------------
interface fetch_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int PC_WIDTH   = 32
);
  logic                  stall;
  logic                  flush;
  logic [PC_WIDTH-1:0]   branch_target;
  logic [PC_WIDTH-1:0]   imem_addr;
  logic [DATA_WIDTH-1:0] imem_rdata;
  logic [PC_WIDTH-1:0]   pc_out;
  logic [PC_WIDTH-1:0]   pc_plus4_out;
  logic [DATA_WIDTH-1:0] ins_out;
  logic                  if_id_valid;

  // master: the fetch stage itself
  modport master (
    input  stall, flush, branch_target, imem_rdata,
    output imem_addr, pc_out, pc_plus4_out, ins_out, if_id_valid
  );

  // slave: the surrounding pipeline, hazard unit and ROM
  modport slave (
    output stall, flush, branch_target, imem_rdata,
    input  imem_addr, pc_out, pc_plus4_out, ins_out, if_id_valid
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fetch_stage
// Brief    : Instruction fetch with stall hold buffer and flush redirect.
// Revision : 1.0
// ----------------------------------------------------------------------------
module fetch_stage #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  PC_WIDTH   = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  wire logic         clk,
  input  wire logic         rst,
  fetch_stage_if.master     bus
);

  // BUBBLE: no valid instr; RUN: instr comes from the ROM; HELD: from hold buffer
  typedef enum logic [1:0] {
    BUBBLE = 2'd0,
    RUN    = 2'd1,
    HELD   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_f_q, pc_f_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0] hold_ins_q, hold_ins_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= BUBBLE;
      pc_f_q     <= RESET_PC;
      pc_q       <= RESET_PC;
      hold_ins_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      pc_f_q     <= pc_f_d;
      pc_q       <= pc_d;
      hold_ins_q <= hold_ins_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_f_d     = pc_f_q;
    pc_d       = pc_q;
    hold_ins_d = hold_ins_q;
    if (bus.flush) begin
      pc_f_d  = {bus.branch_target[PC_WIDTH-1:2], 2'b00};
      state_d = BUBBLE;
    end else if (bus.stall) begin
      // The ROM output moves on after this edge, so latch the current word now
      if (state_q == RUN) begin
        hold_ins_d = bus.imem_rdata;
        state_d    = HELD;
      end
    end else begin
      pc_d    = pc_f_q;
      pc_f_d  = pc_f_q + PC_WIDTH'(4);
      state_d = RUN;
    end
  end

  always_comb begin
    bus.imem_addr    = pc_f_q;
    bus.pc_out       = pc_q;
    bus.pc_plus4_out = pc_q + PC_WIDTH'(4);
    bus.if_id_valid  = (state_q != BUBBLE);
    case (state_q)
      HELD:    bus.ins_out = hold_ins_q;
      RUN:     bus.ins_out = bus.imem_rdata;
      default: bus.ins_out = NOP_INSTR;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_fetch_stage
// Brief    : Directed and random stimulus against an IF/ID reference model.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fetch_stage_if #(.DATA_WIDTH(32), .PC_WIDTH(32)) bus ();

  fetch_stage #(
    .DATA_WIDTH (32),
    .PC_WIDTH   (32),
    .RESET_PC   (RESET_PC),
    .NOP_INSTR  (NOP_INSTR)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [31:0] rom(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  // Synchronous ROM: one-cycle read latency
  always @(posedge clk) bus.imem_rdata <= rom(bus.imem_addr);

  int total = 0;
  int bad   = 0;

  // Reference model in IF/ID terms: what decode should be seeing
  logic [31:0] m_fpc, m_pc, m_ins;
  logic        m_vld;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic f, input logic [31:0] bt);
    rst               = r;
    bus.stall         = s;
    bus.flush         = f;
    bus.branch_target = bt;
    @(posedge clk);
    if (r) begin
      m_fpc = RESET_PC; m_pc = RESET_PC; m_vld = 1'b0; m_ins = NOP_INSTR;
    end else if (f) begin
      m_fpc = {bt[31:2], 2'b00}; m_vld = 1'b0; m_ins = NOP_INSTR;
    end else if (!s) begin
      m_pc = m_fpc; m_ins = rom(m_fpc); m_vld = 1'b1; m_fpc = m_fpc + 32'd4;
    end
    #1;
    chk("imem_addr", bus.imem_addr, m_fpc);
    chk("pc_out", bus.pc_out, m_pc);
    chk("pc_plus4", bus.pc_plus4_out, m_pc + 32'd4);
    chk("ins_out", bus.ins_out, m_ins);
    chk("valid", {31'd0, bus.if_id_valid}, {31'd0, m_vld});
  endtask

  initial begin
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.branch_target = '0;

    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("rst_ins", bus.ins_out, 32'h0000_0013);
    chk("rst_valid", {31'd0, bus.if_id_valid}, 32'd0);

    step(0, 0, 0, 0);
    chk("first_pc", bus.pc_out, 32'h0);
    chk("first_ins", bus.ins_out, 32'h1000_0000);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("pc8", bus.pc_out, 32'h8);

    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      chk("stall_ins", bus.ins_out, 32'h1000_0002);
    end
    step(0, 0, 0, 0);
    chk("post_stall_ins", bus.ins_out, 32'h1000_0003);

    step(0, 0, 1, 32'h40);
    chk("flush_bubble", bus.ins_out, 32'h0000_0013);
    step(0, 0, 0, 0);
    chk("target_ins", bus.ins_out, 32'h1000_0010);

    step(0, 1, 1, 32'h22);
    step(0, 0, 0, 0);
    chk("aligned_pc", bus.pc_out, 32'h20);
    chk("aligned_ins", bus.ins_out, 32'h1000_0008);

    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("rst_stall_pc", bus.pc_out, 32'h0);
    step(0, 0, 0, 0);
    chk("restart_ins", bus.ins_out, 32'h1000_0000);

    step(0, 0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0, 0);
    chk("wrap_plus4", bus.pc_plus4_out, 32'h0);
    step(0, 0, 0, 0);
    chk("wrap_pc", bus.pc_out, 32'h0);

    step(0, 0, 1, 32'h10);
    step(0, 0, 1, 32'h80);
    step(0, 0, 0, 0);
    chk("last_flush_wins", bus.pc_out, 32'h80);

    for (int i = 0; i < 400; i++) begin
      logic r, s, f;
      r = ($urandom_range(0, 49) == 0);
      f = ($urandom_range(0, 9) == 0);
      s = ($urandom_range(0, 3) == 0);
      step(r, s, f, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
